// File: rtl/uart_pkg.sv
// Shared encodings and constants for the multi-requester UART transmitter.
// The PARITY encoding is reserved even when UART_TX_PARITY_EN is not defined.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int   DATA_BITS       = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps.
// Returns a one-hot grant, the index of the winner, and a valid flag.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_idx,
   output logic             o_valid
);

   logic w_found;

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path through
      // the block can leave a value held over and infer a latch.
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
            w_found = 1'b1;
            o_grant[(int'(i_ptr) + k) % N_REQ] = 1'b1;
            o_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
         end
      end
      o_valid = w_found;
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler. It selects a requester, latches that byte and sends start, 8 data LSB-first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT),
   localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [8*N_REQ-1:0]     data,
   output logic [N_REQ-1:0]       grant,
   output logic                   tx,
   output logic                   busy,
   output logic [ID_W-1:0]        cur_id
);

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [2:0]             r_bit_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic [ID_W-1:0]        r_rr_ptr;
   logic [N_REQ-1:0]       r_grant;
   logic                   r_tx;
   logic                   r_busy;
   logic [ID_W-1:0]        r_cur_id;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity;
`endif

   logic                   w_tick;
   logic [N_REQ-1:0]       w_arb_grant;
   logic [ID_W-1:0]        w_arb_idx;
   logic                   w_arb_valid;
   logic [DATA_BITS-1:0]   w_sel_byte;
   logic [ID_W-1:0]        w_next_ptr;
   logic                   w_line;

   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .i_req   (req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_tick     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_sel_byte = data[int'(w_arb_idx)*DATA_BITS +: DATA_BITS];
   assign w_next_ptr = (int'(w_arb_idx) == N_REQ - 1) ? '0 : w_arb_idx + ID_W'(1);

   // tx and busy are registered from the current state and trail it by one
   // cycle, so the grant pulse comes exactly one cycle before the first start-bit cycle.
   always_comb begin
      w_line = UART_IDLE_LEVEL;
      case (r_state)
         S_START:  w_line = ~UART_IDLE_LEVEL;
         S_DATA:   w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_line = r_parity;
`endif
         default:  w_line = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_tx      <= UART_IDLE_LEVEL;
         r_busy    <= 1'b0;
         r_cur_id  <= '0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch
         // reads the values from before this edge, whatever the statement order.
         r_grant <= '0;
         r_tx    <= w_line;
         r_busy  <= (r_state != S_IDLE);
         if (r_state == S_IDLE) r_cnt <= '0;
         else                   r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);

         case (r_state)
            S_IDLE: begin
               r_bit_idx <= '0;
               if (w_arb_valid) begin
                  r_grant  <= w_arb_grant;
                  r_shift  <= w_sel_byte;
                  r_cur_id <= w_arb_idx;
                  r_rr_ptr <= w_next_ptr;
`ifdef UART_TX_PARITY_EN
                  r_parity <= even_parity(w_sel_byte);
`endif
                  r_state  <= S_START;
               end
            end
            S_START: if (w_tick) r_state <= S_DATA;
            S_DATA: begin
               if (w_tick) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (w_tick) r_state <= S_STOP;
`endif
            S_STOP: if (w_tick) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant  = r_grant;
   assign tx     = r_tx;
   assign busy   = r_busy;
   assign cur_id = r_cur_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (N_REQ=4, CLKS_PER_BIT=4) with a frame scoreboard.
// When UART_TX_PARITY_EN is defined, the bench expects the parity bit and 11-bit frames.
module tb_uart_tx_sched;

   localparam int N_REQ = 4;
   localparam int C     = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * C;

   typedef struct {
      int         id;
      logic [7:0] value;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  grant;
   logic        tx;
   logic        busy;
   logic [1:0]  cur_id;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_start = 0;
   exp_t sb_q[$];

   uart_tx_sched #(.N_REQ(N_REQ), .CLKS_PER_BIT(C)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .data   (data),
      .grant  (grant),
      .tx     (tx),
      .busy   (busy),
      .cur_id (cur_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic push_exp(input int id, input logic [7:0] value);
      exp_t e;
      e.id = id;
      e.value = value;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Wait for the grant, check it against the scoreboard, then check the whole frame on tx.
   task automatic run_frame(input logic rel, input logic mut_en, input logic [31:0] mut_data);
      exp_t e;
      int n;
      int busy_hi;
      logic bit_ok;
      logic [FRAME_BITS-1:0] bits;
      if (sb_q.size() == 0) begin
         total++; bad++;
         $display("FAIL sb_empty: no expected frame queued");
         return;
      end
      e = sb_q.pop_front();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant === 4'b0 && n < 200);
      total++;
      if (grant !== 4'(1 << e.id)) begin
         bad++;
         $display("FAIL grant: got %b expected %b", grant, 4'(1 << e.id));
         return;
      end
      total++;
      if (cur_id !== 2'(e.id)) begin
         bad++;
         $display("FAIL cur_id: got %0d expected %0d", cur_id, e.id);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_at_grant: got %b expected 0", busy);
      end
      last_start = cyc + 1;
      if (rel) req[e.id] = 1'b0;
      if (mut_en) data = mut_data;

      bits = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = e.value[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^e.value;
`endif
      bits[FRAME_BITS-1] = 1'b1;

      busy_hi = 0;
      for (int k = 0; k < FRAME_BITS; k++) begin
         bit_ok = 1'b1;
         for (int j = 0; j < C; j++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_hi++;
            if (tx !== bits[k]) bit_ok = 1'b0;
            if (k == 0 && j == 0) begin
               total++;
               if (grant !== 4'b0) begin
                  bad++;
                  $display("FAIL grant_pulse: got %b expected 0000", grant);
               end
            end
         end
         total++;
         if (!bit_ok) begin
            bad++;
            $display("FAIL frame_bit id=%0d byte=%h bit=%0d: tx=%b expected %b", e.id, e.value, k, tx, bits[k]);
         end
      end
      total++;
      if (busy_hi != FRAME_CYC) begin
         bad++;
         $display("FAIL busy_len: got %0d expected %0d", busy_hi, FRAME_CYC);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = 4'b0001;
      data = 32'h0000_0005;
      repeat (3) @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || grant !== 4'b0 || cur_id !== 2'd0) begin
         bad++;
         $display("FAIL reset_state: tx=%b busy=%b grant=%b cur_id=%0d expected 1 0 0000 0", tx, busy, grant, cur_id);
      end
      req = 4'b0000;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      data = 32'h0000_0005;
      req = 4'b0001;
      push_exp(0, 8'h05);
      run_frame(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx !== 1'b1 || grant !== 4'b0) begin
         bad++;
         $display("FAIL single_idle: busy=%b tx=%b grant=%b expected 0 1 0000", busy, tx, grant);
      end
   endtask

   task automatic test_fairness();
      int prev;
      int high;
      do_reset();
      data = 32'hA3A2_A1A0;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(i % 4, 8'hA0 + 8'(i % 4));
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         run_frame(1'b0, 1'b0, 32'h0);
         if (i > 0) begin
            high = last_start - prev - (FRAME_BITS - 1) * C;
            total++;
            if (high != C + 1) begin
               bad++;
               $display("FAIL line_high: got %0d cycles expected %0d", high, C + 1);
            end
         end
         prev = last_start;
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_ptr_wrap();
      do_reset();
      data = 32'h3C00_00C5;
      req = 4'b1000;
      push_exp(3, 8'h3C);
      run_frame(1'b1, 1'b0, 32'h0);
      req = 4'b1001;
      push_exp(0, 8'hC5);
      push_exp(3, 8'h3C);
      run_frame(1'b0, 1'b0, 32'h0);
      run_frame(1'b0, 1'b0, 32'h0);
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int n;
      do_reset();
      data = 32'h0000_003A;
      req = 4'b0001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant === 4'b0 && n < 200);
      total++;
      if (grant !== 4'b0001) begin
         bad++;
         $display("FAIL mid_reset_grant: got %b expected 0001", grant);
      end
      repeat (14) @(negedge clk);
      reset = 1'b1;
      req = 4'b0011;
      data = 32'h0000_963A;
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || grant !== 4'b0) begin
         bad++;
         $display("FAIL mid_reset_abort: tx=%b busy=%b grant=%b expected 1 0 0000", tx, busy, grant);
      end
      reset = 1'b0;
      push_exp(0, 8'h3A);
      push_exp(1, 8'h96);
      run_frame(1'b1, 1'b0, 32'h0);
      run_frame(1'b1, 1'b0, 32'h0);
      @(negedge clk);
   endtask

   task automatic test_stability();
      do_reset();
      data = 32'h1122_5A33;
      req = 4'b0010;
      push_exp(1, 8'h5A);
      run_frame(1'b1, 1'b1, 32'h1122_C333);
      @(negedge clk);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      do_reset();
      data = 32'h0000_0007;
      req = 4'b0001;
      push_exp(0, 8'h07);
      run_frame(1'b1, 1'b0, 32'h0);
      data = 32'h0000_0003;
      req = 4'b0001;
      push_exp(0, 8'h03);
      run_frame(1'b1, 1'b0, 32'h0);
      @(negedge clk);
   endtask
`endif

   initial begin
      reset = 1'b1;
      req = 4'b0000;
      data = 32'h0;
      test_reset();
      test_single();
      test_fairness();
      test_ptr_wrap();
      test_mid_reset();
      test_stability();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: %0d frames never seen", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler and serial-frame sequencer that lets N_REQ requesters share one UART transmit line.
- Selects one requester and latches its byte, then drives the frame on `tx`: start bit, 8 data bits LSB-first, stop bit.
- Sits between the register-side requesters and the serial output pin. It is the control layer above the word-to-serial shift datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2).
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request per requester; held until granted.
- data  input  8*N_REQ  byte per requester; slot i = data[8i+7:8i]; stable while req[i]=1.
- grant  output  N_REQ  one-hot, one-cycle pulse when requester's byte is latched.
- tx  output  1  serial line, idle high.
- busy  output  1  high from the cycle after grant through the last stop-bit cycle.
- cur_id  output  $clog2(N_REQ)  index of requester owning the current frame.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (port `reset`).
- Reset values: tx=1, busy=0, grant=0, cur_id=0, rr_ptr=0, state=IDLE, counters=0.
- FSM states:
  - IDLE: if any req, grant winner, latch byte to shift reg, cur_id=winner, rr_ptr=winner+1 mod N_REQ, go START. Otherwise stay; tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA.
  - DATA: tx=shift[0]; shift right every CLKS_PER_BIT cycles; after 8 bits go STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go IDLE.
- Arbitration: round-robin starting search at rr_ptr. Example: rr_ptr=2, req=4'b0011 → grant 0.
- Grant timing:
  - grant asserts in the same cycle the byte is registered.
  - First start-bit cycle is the next cycle.
  - busy rises with START.
- Back-to-back frames: IDLE lasts exactly one cycle when req is pending, so the line is high for CLKS_PER_BIT+1 cycles between frames.
- Frame length: 10*CLKS_PER_BIT cycles (START through STOP).
- Requester release: a requester that keeps req high after grant is simply eligible again later. No frame is duplicated in the same IDLE cycle.
- req changes during a frame are ignored until IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; it wraps and advances the bit on terminal count.
- Reset mid-frame: the frame is aborted, tx=1 on the next edge, and no grant is issued in that cycle.
- N_REQ=1: arbitration degenerates to req[0].

Optional Feature:
- UART_TX_PARITY_EN defined: a PARITY state follows DATA and sends the even parity bit (XOR of the 8 bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT.
- UART_TX_PARITY_EN undefined: no PARITY state; frame = 10 bits.

Decomposition:
- Shared package/header uart_pkg contains:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - DATA_BITS=8;
  - UART_IDLE_LEVEL=1'b1.
- Natural sub-module: rr_arbiter (req, rr_ptr → one-hot grant, index), purely combinational.
- Baud counter and FSM stay in uart_tx_sched.

Test Plan (CLKS_PER_BIT=4, N_REQ=4):
- Single frame: req=4'b0001, data[7:0]=8'h05 → grant=4'b0001 for one cycle; tx sequence is 0, then 1,0,1,0,0,0,0,0, then 1, each bit 4 cycles; busy high 40 cycles.
- Fairness: all req held high with distinct bytes 8'hA0..8'hA3 → grant order 0,1,2,3,0; each frame decodes to its own byte; 5 line-high cycles between frames.
- Pointer wrap: after grant to 3, req=4'b1001 → next grant to 0; then with req=4'b1001 still held → grant 3.
- Mid-frame reset: reset asserted during the 3rd data bit for 1 cycle → next edge tx=1, busy=0, grant=0; a held req restarts from rr_ptr=0 with a full new frame.
- Stability: change data[15:8] mid-frame of requester 1 → transmitted byte equals the value latched at grant.
- UART_TX_PARITY_EN: send 8'h07 → parity bit 1 after bit 7; frame 44 cycles; 8'h03 → parity 0.
